data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Variable-latency data memory that serves the memory pipeline stage over a valid/ready request, one-shot response handshake. It is the responder end of the stage's load/store interface and replaces the zero-latency array. While a load or store is outstanding it raises a stall to the pipeline, so the memory stage, and every stage behind it, holds until the response arrives. It accepts at most one request at a time and flags misaligned or out-of-range accesses instead of touching storage.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; the legal byte range is 0 to 4*DEPTH_WORDS-1.
- READ_LATENCY, 2: cycles from the accept edge to read data valid; legal values are 1 to 15.
- clk  input  1  clock; one clock domain.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  load or store requested by the memory stage.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; word index is req_addr[31:2].
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  single-cycle completion pulse.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  qualified by rsp_valid: misaligned or out-of-range access.
- stall  output  1  combinational req_valid & ~rsp_valid; freezes the pipeline.

## Operation
- The state machine has three states: IDLE, WAIT and RESP. req_ready = (state == IDLE).
- A request is accepted at any rising edge where req_valid & req_ready. At that edge the responder latches req_we, the word index and the error flag.
- Error condition: req_addr[1:0] != 0, or req_addr[31:2] >= DEPTH_WORDS.
  - On an error the responder goes IDLE->RESP and performs no storage access.
  - In RESP it drives rsp_err=1 and rsp_rdata=0.
- Store without error: the word is written at the accept edge. The responder then goes IDLE->RESP and drives rsp_rdata=0.
- Load without error:
  - If READ_LATENCY==1, go IDLE->RESP.
  - Otherwise go IDLE->WAIT and load a down-counter with READ_LATENCY-2. WAIT decrements it each cycle and moves to RESP when it reaches 0.
  - rsp_rdata is registered from the array on the edge that enters RESP.
- RESP lasts exactly one cycle with rsp_valid=1, then returns to IDLE unconditionally.
- Requester contract:
  - Hold req_valid and all req_* fields stable from assertion until the cycle in which rsp_valid=1.
  - On that cycle's edge the pipeline advances. A request still present in the following IDLE cycle is treated as a new request.
- The storage array is not cleared by reset. Its contents are undefined until written.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. stall follows req_valid, because rsp_valid=0.
- Response timing, for a request accepted at the edge ending cycle T:
  - store or error: rsp_valid in cycle T+1.
  - load: rsp_valid in cycle T+READ_LATENCY.
- Throughput:
  - store or error: one request per 2 cycles.
  - load: one request per READ_LATENCY+1 cycles.
- req_valid low while in WAIT or RESP is a contract violation. The responder still completes the latched request.
- Reset asserted in WAIT or RESP:
  - The next state is IDLE and no rsp_valid pulse is produced.
  - A store already committed at its accept edge persists.
- Reset and req_valid in the same cycle: reset wins and nothing is accepted.
- The read data path uses a word index of width $clog2(DEPTH_WORDS). The range check is done on the full 30-bit index, so high address bits never alias.

## Structure
- Package dmem_pkg holds:
  - the typedef enum logic [1:0] {IDLE, WAIT, RESP} for the state,
  - DATA_W=32 and ADDR_W=32,
  - a function that computes the error flag from the address and the depth.
- Sub-module dmem_array(DEPTH_WORDS) holds the storage: synchronous write enable, combinational read of a word index.
- The responder module contains the state machine, the latency counter, the request latches and the response registers.

## Test plan
- Store 0xDEADBEEF to 0x10 at T, then load 0x10 with READ_LATENCY=2.
  - Store: rsp_valid at T+1 with rsp_rdata=0 and rsp_err=0.
  - Load: rsp_valid exactly 2 cycles after its accept, with rsp_rdata=0xDEADBEEF.
  - stall is high in every cycle up to each rsp_valid.
- Store 0x12345678 to 0x13 (misaligned): rsp_valid at T+1 with rsp_err=1. A following load of 0x10 still returns 0xDEADBEEF.
- Load 0x400 with DEPTH_WORDS=256 (index 256, out of range): rsp_err=1 and rsp_rdata=0 at T+1. Then load 0x3FC after a store of 0xA5A5A5A5 there: returns 0xA5A5A5A5 with rsp_err=0.
- Assert rst for one cycle while in WAIT on a load.
  - No rsp_valid pulse appears.
  - req_ready=1 in the cycle after reset.
  - A re-issued load of the same address completes with the correct data.
- Build with READ_LATENCY=1 and run back-to-back loads of 0x0, 0x4 and 0x8 (written beforehand with 1, 2, 3).
  - rsp_valid pulses in alternating cycles with data 1, 2, 3.
  - req_ready is low exactly in each RESP cycle.
- Build with READ_LATENCY=4 and run a load, then a store, then a load to the same address.
  - First load: response at accept+4 returning the old data.
  - Store: response at accept+1.
  - Second load: response at accept+4 returning the new data.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and address check for the data memory responder
package dmem_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // The full 30-bit word index is compared so that high address bits never alias into the array.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth_words);
        logic [ADDR_W-1:0] word_idx;
        word_idx = {2'b00, addr[ADDR_W-1:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth_words);
    endfunction
endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with synchronous write and combinational read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - variable-latency data memory serving the memory stage over valid/ready
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic              lat_err;
    logic [IDX_W-1:0]  lat_idx;
    logic              req_err;
    logic              accept;
    logic              wr_en;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;

    assign req_err = addr_err(req_addr, DEPTH_WORDS);
    assign req_idx = req_addr[IDX_W+1:2];
    assign accept  = req_valid && (state == IDLE);
    // Stores commit on the accept edge; reset in the same cycle blocks the write.
    assign wr_en   = accept && req_we && !req_err && !rst;
    // A latency-1 load reads on its accept edge, before the index latch is loaded.
    assign rd_idx  = (state == IDLE) ? req_idx : lat_idx;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign stall     = req_valid && !rsp_valid;

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (req_idx),
        .wr_data (req_wdata),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we  <= req_we;
                        lat_err <= req_err;
                        lat_idx <= req_idx;
                        if (req_err || req_we || READ_LATENCY == 1) begin
                            state   <= RESP;
                            rsp_err <= req_err;
                            if (!req_err && !req_we) begin
                                rsp_rdata <= rd_data;
                            end
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(READ_LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_err   <= lat_err;
                        rsp_rdata <= (lat_we || lat_err) ? '0 : rd_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at read latencies 2, 1 and 4
module tb_data_mem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        stall     [3];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int LAT = (g == 1) ? 1 : (g == 2) ? 4 : 2;
            data_mem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(LAT)) dut (
                .clk       (clk),
                .rst       (rst[g]),
                .req_valid (req_valid[g]),
                .req_we    (req_we[g]),
                .req_addr  (req_addr[g]),
                .req_wdata (req_wdata[g]),
                .req_ready (req_ready[g]),
                .rsp_valid (rsp_valid[g]),
                .rsp_rdata (rsp_rdata[g]),
                .rsp_err   (rsp_err[g]),
                .stall     (stall[g])
            );
        end
    endgenerate

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 1) ? 1 : (d == 2) ? 4 : 2;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d", i), 32'(stall[i]), 32'(req_valid[i] & ~rsp_valid[i]));
            if (rsp_valid[i]) begin
                chk($sformatf("ready_in_resp%0d", i), 32'(req_ready[i]), 32'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp%0d: got rsp_valid=1 expected none (cycle %0d)", i, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_inst", 32'(i), 32'(e.inst));
                    chk($sformatf("rsp_rdata%0d", i), rsp_rdata[i], e.rdata);
                    chk($sformatf("rsp_err%0d", i), 32'(rsp_err[i]), 32'(e.err));
                    chk($sformatf("rsp_cycle%0d", i), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Called just after a rising edge with the target in IDLE; returns just after the edge that ends RESP.
    task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        bit   seen;
        chk($sformatf("ready_at_issue%0d", d), 32'(req_ready[d]), 32'd1);
        e.inst  = d;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = cyc + ((we || exp_err) ? 1 : lat_of(d));
        sb.push_back(e);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = rsp_valid[d];
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout%0d: got no rsp_valid expected one within 20 cycles (addr %h)", d, addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int d);
        req_valid[d] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i]       = 1'b1;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'h0;
            req_wdata[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'd1);
            chk($sformatf("rst_valid%0d", i), 32'(rsp_valid[i]), 32'd0);
            chk($sformatf("rst_rdata%0d", i), rsp_rdata[i], 32'd0);
            chk($sformatf("rst_err%0d", i), 32'(rsp_err[i]), 32'd0);
        end

        // latency 2: store/load, misaligned store, out-of-range load, top word
        issue(0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0); drop(0);
        issue(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0); drop(0);
        issue(0, 1'b1, 32'h13,  32'h12345678, 32'h0,        1'b1); drop(0);
        issue(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0); drop(0);
        issue(0, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1); drop(0);
        issue(0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 32'h0,        1'b0);
        issue(0, 1'b0, 32'h3FC, 32'h0,        32'hA5A5A5A5, 1'b0); drop(0);

        // reset while a load waits: no response, ready again, re-issue completes
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h10;
        @(posedge clk);
        #1;
        chk("wait_not_ready", 32'(req_ready[0]), 32'd0);
        rst[0]       = 1'b1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        chk("ready_after_rst", 32'(req_ready[0]), 32'd1);
        chk("valid_after_rst", 32'(rsp_valid[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0); drop(0);

        // latency 1: back-to-back loads
        issue(1, 1'b1, 32'h0, 32'd1, 32'h0, 1'b0);
        issue(1, 1'b1, 32'h4, 32'd2, 32'h0, 1'b0);
        issue(1, 1'b1, 32'h8, 32'd3, 32'h0, 1'b0); drop(1);
        issue(1, 1'b0, 32'h0, 32'h0, 32'd1, 1'b0);
        issue(1, 1'b0, 32'h4, 32'h0, 32'd2, 1'b0);
        issue(1, 1'b0, 32'h8, 32'h0, 32'd3, 1'b0); drop(1);

        // latency 4: load old, store new, load new
        issue(2, 1'b1, 32'h20, 32'h11111111, 32'h0,        1'b0); drop(2);
        issue(2, 1'b0, 32'h20, 32'h0,        32'h11111111, 1'b0);
        issue(2, 1'b1, 32'h20, 32'h22222222, 32'h0,        1'b0);
        issue(2, 1'b0, 32'h20, 32'h0,        32'h22222222, 1'b0); drop(2);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
